// File: rtl/test_pattern_pkg.sv
// Shared definitions for the test pattern source.
// Holds the pattern-mode and FSM-state encodings, plus the PRBS-7 tap
// positions and a single-step helper used by the PRBS generator.
package test_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE  = 2'd0,
    MODE_COUNTER = 2'd1,
    MODE_PRBS7   = 2'd2,
    MODE_CONST   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // x^7 + x^6 + 1, Fibonacci form: feedback is s[6] ^ s[5].
  localparam int PRBS7_TAP_A = 6;
  localparam int PRBS7_TAP_B = 5;

  // One shift-left step; the new bit enters at s[0], s[6] is the output bit.
  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B]};
  endfunction

endpackage

// File: rtl/test_pattern_source_prbs7_gen.sv
// prbs7_gen: PRBS-7 generator producing DATA_W bits per advance.
// Ports:
//   clk, rst    clock, synchronous active-low reset (loads SEED)
//   load        reload the register with SEED (wins over advance)
//   advance     step the register DATA_W bit positions
//   data        DATA_W bits of the current state; the bit that comes out of
//               the register first sits in the MSB
module prbs7_gen
  import test_pattern_pkg::*;
#(
  parameter int         DATA_W = 2,
  parameter logic [6:0] SEED   = 7'h7F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] data
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;
  logic [6:0] walk;

  // Unroll DATA_W serial steps: each step emits s[6] then shifts. The
  // final walk value is the state after this beat has been consumed.
  always_comb begin
    data = '0;
    walk = lfsr_q;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      data[i] = walk[6];
      walk    = prbs7_step(walk);
    end
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED;
    end else if (advance) begin
      lfsr_d = walk;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/test_pattern_source.sv
// test_pattern_source: AXI-Stream test source and sink for bring-up of the
// SDR modulator path.
// Source side drives toggle / counter / PRBS-7 / constant beats in bursts
// of burst_len beats (0 = continuous) separated by gap_len idle cycles.
// Sink side accepts every input beat and counts them (saturating).
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   enable                    run request
//   mode, const_data          pattern select, constant value for mode 3
//   burst_len, gap_len        burst/gap lengths, latched when a run starts
//   out_valid/out_data/out_ready   axis_out stream
//   in_valid/in_data/in_ready      axis_in stream (data discarded)
//   in_count                  accepted input beats, saturating
//   busy                      high while in BURST or GAP
//   dbg_state                 current FSM state (state_e encoding)
//
// Handshake: a beat transfers on a rising edge where valid && ready. Once
// out_valid is high, out_valid and out_data hold until that transfer; valid
// never depends on ready.
module test_pattern_source
  import test_pattern_pkg::*;
#(
  parameter int         DATA_W    = 2,
  parameter int         IN_W      = 24,
  parameter int         LEN_W     = 16,
  parameter logic [6:0] PRBS_SEED = 7'h7F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] const_data,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [LEN_W-1:0]  gap_len,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  output logic              in_ready,
  output logic [31:0]       in_count,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [DATA_W-1:0]  const_q, const_d;
  logic [LEN_W-1:0]   blen_q, blen_d;
  logic [LEN_W-1:0]   glen_q, glen_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               tog_q, tog_d;
  logic [DATA_W-1:0]  cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               in_ready_q;
  logic [31:0]        in_count_q, in_count_d;

  logic               handshake;
  logic               last_beat;
  logic               gap_done;
  logic               prbs_load;
  logic               prbs_adv;
  logic [DATA_W-1:0]  prbs_data;
  logic               in_data_unused;

  assign in_data_unused = ^in_data;

  prbs7_gen #(
    .DATA_W (DATA_W),
    .SEED   (PRBS_SEED)
  ) u_prbs (
    .clk     (clk),
    .rst     (rst),
    .load    (prbs_load),
    .advance (prbs_adv),
    .data    (prbs_data)
  );

  assign handshake = out_valid_q & out_ready;
  assign last_beat = (blen_q != '0) && (beat_cnt_q == blen_q - LEN_W'(1));
  // Only evaluated in GAP, where glen_q is known to be non-zero.
  assign gap_done  = (gap_cnt_q == glen_q - LEN_W'(1));

  // Next-state logic. Pattern state always describes the beat currently
  // presented, so it only moves on a handshake or when a run starts.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    const_d    = const_q;
    blen_d     = blen_q;
    glen_d     = glen_q;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tog_d      = tog_q;
    cnt_d      = cnt_q;
    prbs_load  = 1'b0;
    prbs_adv   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d    = ST_BURST;
          mode_d     = mode_e'(mode);
          const_d    = const_data;
          blen_d     = burst_len;
          glen_d     = gap_len;
          beat_cnt_d = '0;
          tog_d      = 1'b0;
          cnt_d      = '0;
          prbs_load  = 1'b1;
        end
      end
      ST_BURST: begin
        if (handshake) begin
          tog_d    = ~tog_q;
          cnt_d    = cnt_q + DATA_W'(1);
          prbs_adv = 1'b1;
          if (!enable) begin
            // Dropping enable ends the run right after the pending beat.
            state_d = ST_IDLE;
          end else if (last_beat) begin
            beat_cnt_d = '0;
            if (glen_q == '0) begin
              state_d = ST_BURST;
            end else begin
              state_d   = ST_GAP;
              gap_cnt_d = '0;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          state_d    = enable ? ST_BURST : ST_IDLE;
          beat_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + LEN_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered flags track the state being entered.
    out_valid_d = (state_d == ST_BURST);
    busy_d      = (state_d != ST_IDLE);
  end

  // Pattern mux; every source is already registered.
  always_comb begin
    case (mode_q)
      MODE_TOGGLE:  out_data = {DATA_W{tog_q}};
      MODE_COUNTER: out_data = cnt_q;
      MODE_PRBS7:   out_data = prbs_data;
      default:      out_data = const_q;
    endcase
  end

  // Sink: always ready out of reset, saturating beat counter.
  always_comb begin
    in_count_d = in_count_q;
    if (in_valid && in_ready_q && (in_count_q != 32'hFFFF_FFFF)) begin
      in_count_d = in_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_TOGGLE;
      const_q     <= '0;
      blen_q      <= '0;
      glen_q      <= '0;
      beat_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      tog_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      in_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      const_q     <= const_d;
      blen_q      <= blen_d;
      glen_q      <= glen_d;
      beat_cnt_q  <= beat_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      tog_q       <= tog_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= 1'b1;
      in_count_q  <= in_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign in_count  = in_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_test_pattern_source.sv
// Bench for test_pattern_source (DATA_W=2).
// Table-driven runs (fixed + random configs) checked beat-by-beat against a
// pattern model, plus hand sequences for enable-drop stall, sink counting,
// saturation and reset mid-stream.
module tb_test_pattern_source;
  import test_pattern_pkg::*;

  localparam int DATA_W = 2;
  localparam int IN_W   = 24;
  localparam int LEN_W  = 16;
  localparam int NBEATS = 140;
  localparam int NVEC   = 10;
  localparam int BUDGET = 3000;

  logic              clk;
  logic              rst;
  logic              enable;
  logic [1:0]        mode;
  logic [DATA_W-1:0] const_data;
  logic [LEN_W-1:0]  burst_len;
  logic [LEN_W-1:0]  gap_len;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              in_valid;
  logic [IN_W-1:0]   in_data;
  logic              in_ready;
  logic [31:0]       in_count;
  logic              busy;
  logic [1:0]        dbg_state;

  test_pattern_source #(
    .DATA_W    (DATA_W),
    .IN_W      (IN_W),
    .LEN_W     (LEN_W),
    .PRBS_SEED (7'h7F)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .const_data (const_data),
    .burst_len  (burst_len),
    .gap_len    (gap_len),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .in_count   (in_count),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q[$];
  bit prbs_bits[127];

  typedef struct {
    logic [1:0]          mode;
    logic [DATA_W-1:0]   cdata;
    int                  blen;
    int                  glen;
    bit                  rand_ready;
    bit                  has_exp;
    logic [6*DATA_W-1:0] exp6;   // {beat5, ..., beat0}
  } vec_t;

  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // PRBS-7 output bits satisfy o[n+7] = o[n] ^ o[n+1]; first 7 bits are
  // the seed read from bit 6 down to bit 0. Period 127.
  task automatic build_prbs();
    logic [6:0] seed;
    seed = 7'h7F;
    for (int n = 0; n < 7; n++) prbs_bits[n] = seed[6-n];
    for (int n = 7; n < 127; n++) prbs_bits[n] = prbs_bits[n-7] ^ prbs_bits[n-6];
  endtask

  // Expected value of beat j (counted from the start of a run).
  function automatic logic [DATA_W-1:0] model_beat(input logic [1:0] m,
                                                   input logic [DATA_W-1:0] c,
                                                   input int j);
    logic [DATA_W-1:0] v;
    v = '0;
    case (m)
      2'd0:    v = (j % 2 == 1) ? '1 : '0;
      2'd1:    v = DATA_W'(j % (1 << DATA_W));
      2'd2:    for (int b = 0; b < DATA_W; b++) v[DATA_W-1-b] = prbs_bits[(j*DATA_W + b) % 127];
      default: v = c;
    endcase
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    int n;
    int cyc;
    int gap_left;
    bit stall;
    logic [DATA_W-1:0] held;
    logic [DATA_W-1:0] want;
    exp_q.delete();
    for (int j = 0; j < NBEATS; j++) exp_q.push_back(model_beat(v.mode, v.cdata, j));
    mode       = v.mode;
    const_data = v.cdata;
    burst_len  = LEN_W'(v.blen);
    gap_len    = LEN_W'(v.glen);
    out_ready  = 1'b0;
    enable     = 1'b1;
    n = 0; cyc = 0; gap_left = 0; stall = 1'b0; held = '0;
    while (n < NBEATS && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      check($sformatf("v%0d valid cyc%0d", idx, cyc), 32'(out_valid), (gap_left > 0) ? 0 : 1);
      if (gap_left > 0) gap_left--;
      if (out_valid) begin
        if (stall) check($sformatf("v%0d hold cyc%0d", idx, cyc), 32'(out_data), 32'(held));
        out_ready = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_ready) begin
          want = exp_q.pop_front();
          check($sformatf("v%0d beat%0d", idx, n), 32'(out_data), 32'(want));
          if (v.has_exp && n < 6)
            check($sformatf("v%0d table beat%0d", idx, n), 32'(out_data), 32'(v.exp6[n*DATA_W +: DATA_W]));
          n++;
          if (v.blen > 0 && v.glen > 0 && (n % v.blen) == 0) gap_left = v.glen;
          if (n == NBEATS) enable = 1'b0;
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          held  = out_data;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        stall     = 1'b0;
      end
    end
    if (n < NBEATS) begin
      total++;
      bad++;
      $display("FAIL v%0d timeout: got %0d beats want %0d", idx, n, NBEATS);
      enable = 1'b0;
      do_reset();
    end
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("v%0d end busy", idx), 32'(busy), 0);
    check($sformatf("v%0d end valid", idx), 32'(out_valid), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0; enable = 1'b0; mode = 2'd0; const_data = '0;
    burst_len = '0; gap_len = '0; out_ready = 1'b0;
    in_valid = 1'b0; in_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst out_valid", 32'(out_valid), 0);
    check("rst out_data", 32'(out_data), 0);
    check("rst in_ready", 32'(in_ready), 0);
    check("rst in_count", in_count, 0);
    check("rst busy", 32'(busy), 0);
    check("rst state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    build_prbs();
    vecs[0] = '{mode: 2'd0, cdata: 2'd0, blen: 0, glen: 0, rand_ready: 1'b0, has_exp: 1'b1,
                exp6: {2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0}};
    vecs[1] = '{mode: 2'd1, cdata: 2'd0, blen: 4, glen: 3, rand_ready: 1'b0, has_exp: 1'b1,
                exp6: {2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[2] = '{mode: 2'd2, cdata: 2'd0, blen: 0, glen: 0, rand_ready: 1'b0, has_exp: 1'b1,
                exp6: {2'd0, 2'd0, 2'd2, 2'd3, 2'd3, 2'd3}};
    vecs[3] = '{mode: 2'd3, cdata: 2'd2, blen: 5, glen: 0, rand_ready: 1'b1, has_exp: 1'b1,
                exp6: {2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2}};
    vecs[4] = '{mode: 2'd1, cdata: 2'd0, blen: 0, glen: 2, rand_ready: 1'b1, has_exp: 1'b1,
                exp6: {2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[5] = '{mode: 2'd2, cdata: 2'd1, blen: 3, glen: 2, rand_ready: 1'b1, has_exp: 1'b1,
                exp6: {2'd0, 2'd0, 2'd2, 2'd3, 2'd3, 2'd3}};
    for (int i = 6; i < NVEC; i++) begin
      vecs[i] = '{mode: 2'($urandom_range(0, 3)), cdata: 2'($urandom_range(0, 3)),
                  blen: int'($urandom_range(0, 6)), glen: int'($urandom_range(0, 4)),
                  rand_ready: 1'($urandom_range(0, 1)), has_exp: 1'b0, exp6: '0};
    end
    for (int i = 0; i < NVEC; i++) run_vector(vecs[i], i);

    // Enable dropped mid-burst while stalled: beat 3 held, then IDLE.
    mode = 2'd1; burst_len = '0; gap_len = '0;
    enable = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("drop beat%0d", k), 32'(out_data), k);
    end
    @(negedge clk);
    check("drop pending data", 32'(out_data), 3);
    out_ready = 1'b0;
    enable    = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("drop stall valid%0d", k), 32'(out_valid), 1);
      check($sformatf("drop stall data%0d", k), 32'(out_data), 3);
      check($sformatf("drop stall busy%0d", k), 32'(busy), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drop after valid", 32'(out_valid), 0);
    check("drop after busy", 32'(busy), 0);
    check("drop after state", 32'(dbg_state), 32'(ST_IDLE));

    // Sink: 10 beats counted.
    do_reset();
    check("sink in_ready", 32'(in_ready), 1);
    check("sink start count", in_count, 0);
    in_valid = 1'b1;
    repeat (10) begin
      in_data = IN_W'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("sink count10", in_count, 10);
    @(negedge clk);
    check("sink count hold", in_count, 10);

    // Saturation: preload near the top, then 3 beats.
    force dut.in_count_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.in_count_q;
    check("sat preload", in_count, 32'hFFFF_FFFE);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("sat count", in_count, 32'hFFFF_FFFF);

    // Reset mid-stream.
    mode = 2'd1; burst_len = 16'd3; gap_len = 16'd1;
    enable = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("pre-rst busy", 32'(busy), 1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst out_valid", 32'(out_valid), 0);
    check("midrst out_data", 32'(out_data), 0);
    check("midrst in_ready", 32'(in_ready), 0);
    check("midrst in_count", in_count, 0);
    check("midrst busy", 32'(busy), 0);
    enable = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
